instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Read-side master of the instruction memory. Drives a byte-address PC into InstructionMemory and captures the returned instruction word.
- Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake.
- Handles start, branch redirect, wrap-around and a HALT sentinel.
- Sits between InstructionMemory (read port) and the decode stage.

Parameters:
- ADDR_W, 8: PC / imem_addr width in bits. Byte address, word aligned.
- RESET_PC, 0: PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops fetching.
- CNT_W, 16: width of the fetched-instruction counter.

Ports:
- CLk, input, 1: single clock. All state updates on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse; begin or resume fetching.
- redirect_valid, input, 1: branch/jump taken this cycle.
- redirect_pc, input, ADDR_W: redirect target. Bits [1:0] are ignored and forced to 0.
- imem_addr, output, ADDR_W: address to InstructionMemory. Equals the current PC.
- imem_rd_en, output, 1: high in cycles where the fetch captures imem_data.
- imem_data, input, 32: instruction from memory. Combinational read, valid in the same cycle as imem_addr.
- out_valid, output, 1: queue head valid.
- out_ready, input, 1: decode accepts the head.
- out_instr, output, 32: queue head instruction.
- out_pc, output, ADDR_W: PC of the queue head.
- halted, output, 1: state is HALT.
- fetch_count, output, CNT_W: number of captured words. Saturates at all-ones.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0, imem_rd_en=0.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN on start.
  - RUN -> HALT when the captured word equals HALT_WORD.
  - HALT -> RUN on start (resume at the current pc) or on redirect_valid.
- pop = out_valid && out_ready. Removes the head at the clock edge.
- capture = (state==RUN) && !redirect_valid && (count<2 || pop). imem_rd_en = capture.
- On capture:
  - {imem_data, pc} is enqueued at the tail.
  - pc <= pc+4, modulo 2^ADDR_W, so pc wraps from 2^ADDR_W-4 to 0.
  - fetch_count increments, saturating.
- HALT_WORD capture: the word is enqueued and delivered to decode; pc is NOT incremented; state -> HALT.
- Redirect has highest priority:
  - queue flushed, including any simultaneous pop (the popped word counts as delivered) and any simultaneous capture (suppressed).
  - pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - In RUN or HALT: state -> RUN.
  - In IDLE: pc updates and state stays IDLE.
- start in RUN is ignored. start and redirect in the same cycle: redirect wins; state -> RUN (from IDLE too).
- Queue full (count=2) and no pop: no capture, pc holds, imem_rd_en=0.
- Queue full with pop: capture and pop happen in the same cycle; count stays 2.
- Empty queue with out_ready=1: no pop; out_valid=0.
- Output ordering is strictly FIFO. out_instr/out_pc hold stable while out_valid && !out_ready.
- Latency:
  - start sampled at edge t, RUN from edge t; first capture at edge t+1; out_valid high after edge t+1.
  - Redirect at edge t: the target word is valid after edge t+1.
- Throughput: one instruction per cycle when out_ready=1 continuously.

Decomposition:
- Shared package (fetch_pkg): state encoding (IDLE=2'd0, RUN=2'd1, HALT=2'd2), HALT_WORD default, PC increment constant 4.
- One sub-module, fetch_queue: 2-entry FIFO of {instr, pc}.
  - Ports: push, pop, flush, full, empty, head.
  - flush overrides push/pop.

Test Plan:
- Reset then idle: hold reset_n=0, release, no start for 5 cycles -> imem_rd_en=0, out_valid=0, imem_addr=0, fetch_count=0.
- Streaming: memory words 0x10,0x11,0x12,... at word addresses 0,4,8,...; start pulse, out_ready=1 -> out_valid after 2 edges; out_instr 0x10,0x11,0x12 with out_pc 0,4,8 on consecutive cycles; fetch_count=3 after 3 captures.
- Backpressure: out_ready=0 after start -> exactly 2 captures; pc=8 held; out_instr stays 0x10; imem_rd_en=0. Raise out_ready -> resumes with 0x11, 0x12, no duplicates or gaps.
- Redirect with full queue: redirect_valid=1, redirect_pc=8'h23 -> queue flushed, out_valid=0 next cycle, then out_pc=0x20 with the matching instruction.
- HALT: HALT_WORD at address 0x0C -> delivered with out_pc=0x0C; halted=1; pc stays 0x0C; no further imem_rd_en. A later start resumes at pc=0x0C.
- Wrap and async reset: run from pc=0xF8 -> out_pc 0xF8, 0xFC, 0x00. Assert reset_n mid-stream (off-edge) -> outputs cleared immediately, state IDLE, pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// default HALT sentinel and the sequential PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int          PC_INC            = 4;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc} pairs between the fetch logic and decode.
// slot0 is always the head; flush empties the queue and overrides push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] data,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign head    = slot0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // A simultaneous pop and push keeps the occupancy and shifts the tail up
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else if (do_pop && do_push) begin
      if (count == 2'd2) begin
        slot0 <= slot1;
        slot1 <= data;
      end else begin
        slot0 <= data;
      end
    end else if (do_pop) begin
      slot0 <= slot1;
      count <= count - 2'd1;
    end else if (do_push) begin
      if (count == 2'd0) begin
        slot0 <= data;
      end else begin
        slot1 <= data;
      end
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives the PC into instruction memory, queues returned words
// and hands them to decode; supports start, redirect, wrap and HALT.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = HALT_WORD_DEFAULT,
  parameter int                CNT_W     = 16
) (
  input  logic              CLk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [31:0]       imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int QW = 32 + ADDR_W;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              q_full;
  logic              q_empty;
  logic [QW-1:0]     q_head;
  logic              pop;
  logic              capture;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid  = !q_empty;
  assign pop        = out_valid && out_ready;
  assign capture    = (state == RUN) && !redirect_valid && (!q_full || pop);
  assign imem_rd_en = capture;
  assign imem_addr  = pc;
  assign out_instr  = q_head[QW-1:ADDR_W];
  assign out_pc     = q_head[ADDR_W-1:0];

  fetch_queue #(
    .W(QW)
  ) u_queue (
    .clk    (CLk),
    .reset_n(reset_n),
    .push   (capture),
    .pop    (pop),
    .flush  (redirect_valid),
    .data   ({imem_data, pc}),
    .full   (q_full),
    .empty  (q_empty),
    .head   (q_head)
  );

  // Redirect outranks everything; a HALT capture parks the PC on the sentinel
  always_ff @(posedge CLk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (capture && (fetch_count != {CNT_W{1'b1}})) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end
      if (redirect_valid) begin
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        if ((state != IDLE) || start) begin
          state  <= RUN;
          halted <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (capture) begin
              if (imem_data == HALT_WORD) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                pc <= pc + ADDR_W'(PC_INC);
              end
            end
          end
          HALT: begin
            if (start) begin
              state  <= RUN;
              halted <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a scoreboard queue holds the
// expected {instr, pc} stream and a negedge monitor checks every handshake.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  pc;
  } exp_t;

  logic        CLk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];
  exp_t        sb [$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 CLk = ~CLk;

  assign imem_data = mem[imem_addr[7:2]];

  instruction_fetch_unit dut (
    .CLk           (CLk),
    .reset_n       (reset_n),
    .start         (start),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rd_en    (imem_rd_en),
    .imem_data     (imem_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rv, input logic [7:0] rp, input logic rdy);
    start          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    out_ready      = rdy;
  endtask

  task automatic tick();
    @(posedge CLk);
    #1;
  endtask

  task automatic expectWord(input logic [31:0] instr, input logic [7:0] pc);
    sb.push_back({instr, pc});
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic waitHalted(input string name);
    int n;
    n = 0;
    while (!halted && n < 30) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(halted), 32'd1);
  endtask

  // Monitor: every accepted head must be the next scoreboard entry
  always @(negedge CLk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_output: got instr 0x%0h pc 0x%0h, expected none", out_instr, out_pc);
      end else begin
        e = sb.pop_front();
        checkOutput("out_instr", out_instr, e.instr);
        checkOutput("out_pc", 32'(out_pc), 32'(e.pc));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h10 + 32'(i);
    mem[3]  = HALT_W;
    mem[10] = HALT_W;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #10;

    // Reset state, checked while reset is held
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_imem_rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_fetch_count", 32'(fetch_count), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_pc", 32'(out_pc), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    checkOutput("idle_imem_rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("idle_fetch_count", 32'(fetch_count), 32'd0);

    // Streaming into the HALT sentinel at 0x0C
    expectWord(32'h10, 8'h00);
    expectWord(32'h11, 8'h04);
    expectWord(32'h12, 8'h08);
    expectWord(HALT_W, 8'h0C);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("lat_out_valid_low", 32'(out_valid), 32'd0);
    checkOutput("lat_imem_rd_en", 32'(imem_rd_en), 32'd1);
    checkOutput("lat_imem_addr", 32'(imem_addr), 32'd0);
    tick();
    checkOutput("lat_out_valid_high", 32'(out_valid), 32'd1);
    checkOutput("stream_count1", 32'(fetch_count), 32'd1);
    tick();
    tick();
    checkOutput("stream_count3", 32'(fetch_count), 32'd3);
    tick();
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_pc", 32'(imem_addr), 32'h0C);
    checkOutput("halt_count", 32'(fetch_count), 32'd4);
    repeat (3) tick();
    checkOutput("halt_no_rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("halt_pc_hold", 32'(imem_addr), 32'h0C);
    checkOutput("halt_drained", 32'(sb.size()), 32'd0);

    // Resume from HALT re-fetches at the parked PC
    expectWord(HALT_W, 8'h0C);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("resume_halted_low", 32'(halted), 32'd0);
    checkOutput("resume_rd_en", 32'(imem_rd_en), 32'd1);
    checkOutput("resume_addr", 32'(imem_addr), 32'h0C);
    tick();
    checkOutput("resume_halted_high", 32'(halted), 32'd1);
    checkOutput("resume_count", 32'(fetch_count), 32'd5);
    repeat (2) tick();
    checkOutput("resume_drained", 32'(sb.size()), 32'd0);

    // Backpressure: two captures, then stall
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (4) tick();
    checkOutput("bp_pc_hold", 32'(imem_addr), 32'h08);
    checkOutput("bp_rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_head_instr", out_instr, 32'h10);
    checkOutput("bp_head_pc", 32'(out_pc), 32'h00);
    checkOutput("bp_count", 32'(fetch_count), 32'd2);
    expectWord(32'h10, 8'h00);
    expectWord(32'h11, 8'h04);
    expectWord(32'h12, 8'h08);
    expectWord(HALT_W, 8'h0C);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    waitHalted("bp_halt");
    repeat (2) tick();
    checkOutput("bp_drained", 32'(sb.size()), 32'd0);
    checkOutput("bp_final_count", 32'(fetch_count), 32'd4);

    // Redirect with a full queue to unaligned 0x23
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    checkOutput("rd_pre_full_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h23, 1'b0);
    checkOutput("rd_no_capture", 32'(imem_rd_en), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("rd_flushed", 32'(out_valid), 32'd0);
    checkOutput("rd_target", 32'(imem_addr), 32'h20);
    expectWord(32'h18, 8'h20);
    expectWord(32'h19, 8'h24);
    expectWord(HALT_W, 8'h28);
    tick();
    checkOutput("rd_valid", 32'(out_valid), 32'd1);
    checkOutput("rd_head_pc", 32'(out_pc), 32'h20);
    checkOutput("rd_head_instr", out_instr, 32'h18);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    waitHalted("rd_halt");
    repeat (2) tick();
    checkOutput("rd_drained", 32'(sb.size()), 32'd0);

    // Redirect in IDLE moves the PC but does not start fetching
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h37, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("idle_rd_pc", 32'(imem_addr), 32'h34);
    repeat (2) tick();
    checkOutput("idle_rd_no_fetch", 32'(imem_rd_en), 32'd0);
    checkOutput("idle_rd_count", 32'(fetch_count), 32'd0);

    // Wrap from 0xF8 (start+redirect from IDLE), then async reset mid-stream
    doReset();
    expectWord(32'h4E, 8'hF8);
    expectWord(32'h4F, 8'hFC);
    expectWord(32'h10, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'hF8, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("wrap_start_pc", 32'(imem_addr), 32'hF8);
    repeat (3) tick();
    #6;
    reset_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("async_rd_en", 32'(imem_rd_en), 32'd0);
    checkOutput("async_count", 32'(fetch_count), 32'd0);
    checkOutput("async_out_instr", out_instr, 32'd0);
    checkOutput("async_out_pc", 32'(out_pc), 32'd0);
    checkOutput("wrap_drained", 32'(sb.size()), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    checkOutput("post_reset_idle", 32'(imem_rd_en), 32'd0);
    checkOutput("post_reset_pc", 32'(imem_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
